// File: rtl/execute_md.sv
// Execute stage: single-cycle ALU with three-source forwarding and an iterative
// RV32M multiply/divide unit that stalls the front end while it works.
module execute_md #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            debug,
  input  logic            ID_EX_valid,
  input  logic            ID_EX_md,
  input  logic [2:0]      ID_EX_mdop,
  input  logic [2:0]      ID_EX_alusel,
  input  logic            ID_EX_alusrc,
  input  logic            ID_EX_regwrite,
  input  logic [4:0]      ID_EX_rs1,
  input  logic [4:0]      ID_EX_rs2,
  input  logic [4:0]      ID_EX_rd,
  input  logic [XLEN-1:0] ID_EX_dout_rs1,
  input  logic [XLEN-1:0] ID_EX_dout_rs2,
  input  logic [XLEN-1:0] ID_EX_imm,
  input  logic            MEM_WB_regwrite,
  input  logic            WB_ID_regwrite,
  input  logic [4:0]      MEM_WB_rd,
  input  logic [4:0]      WB_ID_rd,
  input  logic [XLEN-1:0] WB_res,
  input  logic [XLEN-1:0] WB_ID_res,
  output logic            EX_stall,
  output logic            EX_MEM_valid,
  output logic            EX_MEM_regwrite,
  output logic [4:0]      EX_MEM_rd,
  output logic [XLEN-1:0] EX_MEM_alures,
  output logic [XLEN-1:0] EX_MEM_dout_rs2
);
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, bm_q, bm_d;
  logic            neg_q, neg_d, spec_q, spec_d;
  logic            vld_q, vld_d, rw_q, rw_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d, d2_q, d2_d;

  logic [XLEN-1:0] fwd1, fwd2, op_a, op_b, alu_res, md_res;
  logic            stall;

  // Forwarding: youngest producer wins; x0 is never forwarded.
  always_comb begin
    fwd1 = ID_EX_dout_rs1;
    fwd2 = ID_EX_dout_rs2;
    if (ID_EX_rs1 != 5'd0) begin
      if (vld_q && rw_q && rd_q == ID_EX_rs1)               fwd1 = res_q;
      else if (MEM_WB_regwrite && MEM_WB_rd == ID_EX_rs1)   fwd1 = WB_res;
      else if (WB_ID_regwrite && WB_ID_rd == ID_EX_rs1)     fwd1 = WB_ID_res;
    end
    if (ID_EX_rs2 != 5'd0) begin
      if (vld_q && rw_q && rd_q == ID_EX_rs2)               fwd2 = res_q;
      else if (MEM_WB_regwrite && MEM_WB_rd == ID_EX_rs2)   fwd2 = WB_res;
      else if (WB_ID_regwrite && WB_ID_rd == ID_EX_rs2)     fwd2 = WB_ID_res;
    end
  end

  assign op_a = fwd1;
  assign op_b = ID_EX_alusrc ? ID_EX_imm : fwd2;

  always_comb begin
    case (ID_EX_alusel)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = op_a << op_b[SHW-1:0];
      3'b110:  alu_res = op_a >> op_b[SHW-1:0];
      default: alu_res = $signed(op_a) >>> op_b[SHW-1:0];
    endcase
  end

  // Operand decode at issue: signedness per op, magnitudes, special divides.
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  assign is_div   = ID_EX_mdop[2];
  assign sgn_a    = !(ID_EX_mdop[0] && (ID_EX_mdop[1] || ID_EX_mdop[2]));
  assign sgn_b    = is_div ? !ID_EX_mdop[0] : !ID_EX_mdop[1];
  assign a_neg    = sgn_a && op_a[XLEN-1];
  assign b_neg    = sgn_b && op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;
  assign div0     = is_div && (op_b == '0);
  assign ovf      = is_div && !ID_EX_mdop[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
  assign spec_res = div0 ? (ID_EX_mdop[1] ? op_a : '1) : (ID_EX_mdop[1] ? '0 : op_a);

  // One iteration: shift-add for multiply, restoring step for divide.
  logic [XLEN:0] sum, rem_s, trial;
  assign sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bm_q} : '0);
  assign rem_s = {hi_q, lo_q[XLEN-1]};
  assign trial = rem_s - {1'b0, bm_q};

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_f;
  assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s  = neg_q ? -lo_q : lo_q;
  assign rem_f  = neg_q ? -hi_q : hi_q;

  always_comb begin
    case (ID_EX_mdop)
      3'b000:         md_res = prod_s[XLEN-1:0];
      3'b100, 3'b101: md_res = quo_s;
      3'b110, 3'b111: md_res = rem_f;
      default:        md_res = prod_s[2*XLEN-1:XLEN];
    endcase
    if (spec_q) md_res = lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bm_d    = bm_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (ID_EX_valid && ID_EX_md && !debug) begin
        stall = 1'b1;
        hi_d  = '0;
        bm_d  = b_mag;
        neg_d = (is_div && ID_EX_mdop[1]) ? a_neg : (a_neg ^ b_neg);
        if (div0 || ovf) begin
          spec_d  = 1'b1;
          lo_d    = spec_res;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          spec_d  = 1'b0;
          lo_d    = a_mag;
          cnt_d   = CW'(XLEN);
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (!debug) begin
          if (is_div) begin
            if (!trial[XLEN]) begin
              hi_d = trial[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = rem_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE:    if (!debug) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign EX_stall = stall && !Rst;

  always_comb begin
    vld_d = vld_q;
    rw_d  = rw_q;
    rd_d  = rd_q;
    res_d = res_q;
    d2_d  = d2_q;
    if (!debug) begin
      if (state_q == DONE || (!stall && ID_EX_valid && !ID_EX_md)) begin
        vld_d = 1'b1;
        rw_d  = ID_EX_regwrite;
        rd_d  = ID_EX_rd;
        res_d = (state_q == DONE) ? md_res : alu_res;
        d2_d  = fwd2;
      end else begin
        vld_d = 1'b0;
        rw_d  = 1'b0;
        rd_d  = '0;
        res_d = '0;
        d2_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bm_q    <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      vld_q   <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bm_q    <= bm_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      vld_q   <= vld_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      d2_q    <= d2_d;
    end
  end

  assign EX_MEM_valid    = vld_q;
  assign EX_MEM_regwrite = rw_q;
  assign EX_MEM_rd       = rd_q;
  assign EX_MEM_alures   = res_q;
  assign EX_MEM_dout_rs2 = d2_q;
endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: directed ALU/MD vectors push expectations,
// a negedge monitor pops and compares every valid EX/MEM result.
module tb_execute_md;
  logic        clk = 1'b0, Rst, debug;
  logic        ID_EX_valid, ID_EX_md, ID_EX_alusrc, ID_EX_regwrite;
  logic [2:0]  ID_EX_mdop, ID_EX_alusel;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd, MEM_WB_rd, WB_ID_rd;
  logic [31:0] ID_EX_dout_rs1, ID_EX_dout_rs2, ID_EX_imm, WB_res, WB_ID_res;
  logic        MEM_WB_regwrite, WB_ID_regwrite;
  logic        EX_stall, EX_MEM_valid, EX_MEM_regwrite;
  logic [4:0]  EX_MEM_rd;
  logic [31:0] EX_MEM_alures, EX_MEM_dout_rs2;

  execute_md #(.XLEN(32)) dut (
    .clk(clk), .Rst(Rst), .debug(debug),
    .ID_EX_valid(ID_EX_valid), .ID_EX_md(ID_EX_md), .ID_EX_mdop(ID_EX_mdop),
    .ID_EX_alusel(ID_EX_alusel), .ID_EX_alusrc(ID_EX_alusrc), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_dout_rs1(ID_EX_dout_rs1), .ID_EX_dout_rs2(ID_EX_dout_rs2), .ID_EX_imm(ID_EX_imm),
    .MEM_WB_regwrite(MEM_WB_regwrite), .WB_ID_regwrite(WB_ID_regwrite),
    .MEM_WB_rd(MEM_WB_rd), .WB_ID_rd(WB_ID_rd), .WB_res(WB_res), .WB_ID_res(WB_ID_res),
    .EX_stall(EX_stall), .EX_MEM_valid(EX_MEM_valid), .EX_MEM_regwrite(EX_MEM_regwrite),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_alures(EX_MEM_alures), .EX_MEM_dout_rs2(EX_MEM_dout_rs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] d2;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!Rst && EX_MEM_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got rd=%0d res=%h expected no result", EX_MEM_rd, EX_MEM_alures);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alures", EX_MEM_alures, e.res);
        chk("rd", {27'd0, EX_MEM_rd}, {27'd0, e.rd});
        chk("dout_rs2", EX_MEM_dout_rs2, e.d2);
        chk("regwrite", {31'd0, EX_MEM_regwrite}, 32'd1);
      end
    end
  end

  task automatic idle(input int n);
    ID_EX_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one instruction, counts stall cycles, optionally freezes with debug.
  task automatic run_op(input logic md, input logic [2:0] op, input logic src,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [31:0] eres, input logic [31:0] ed2,
                        input int estall, input int dbg_at);
    exp_t e;
    int   stalls = 0, dbg_left = 0;
    bit   done = 0;
    ID_EX_valid = 1'b1; ID_EX_md = md; ID_EX_regwrite = 1'b1;
    ID_EX_mdop = op; ID_EX_alusel = op; ID_EX_alusrc = src;
    ID_EX_rs1 = rs1; ID_EX_rs2 = rs2; ID_EX_rd = rd;
    ID_EX_dout_rs1 = v1; ID_EX_dout_rs2 = v2; ID_EX_imm = imm;
    e.rd = rd; e.res = eres; e.d2 = ed2;
    sb.push_back(e);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (EX_stall) begin
        stalls++;
        if (stalls == 2) chk("bubble_valid", {31'd0, EX_MEM_valid}, 32'd0);
        if (stalls == dbg_at) begin
          debug = 1'b1;
          dbg_left = 5;
        end else if (dbg_left > 0) begin
          dbg_left--;
          if (dbg_left == 0) debug = 1'b0;
        end
      end else done = 1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL stall_timeout: got %0d stall cycles expected %0d", stalls, estall);
      debug = 1'b0;
    end else chk("stall_cycles", stalls, estall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; debug = 1'b0;
    ID_EX_valid = 0; ID_EX_md = 0; ID_EX_mdop = 0; ID_EX_alusel = 0; ID_EX_alusrc = 0;
    ID_EX_regwrite = 0; ID_EX_rs1 = 0; ID_EX_rs2 = 0; ID_EX_rd = 0;
    ID_EX_dout_rs1 = 0; ID_EX_dout_rs2 = 0; ID_EX_imm = 0;
    MEM_WB_regwrite = 0; WB_ID_regwrite = 0; MEM_WB_rd = 0; WB_ID_rd = 0;
    WB_res = 0; WB_ID_res = 0;
    #3;
    chk("rst_valid", {31'd0, EX_MEM_valid}, 32'd0);
    chk("rst_alures", EX_MEM_alures, 32'd0);
    chk("rst_stall", {31'd0, EX_stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    idle(1);

    // Back-to-back ADD then SUB forwarding from EX_MEM.
    run_op(0, 3'b000, 0, 5'd3, 5'd4, 5'd1, 32'd5, 32'd7, 32'd0, 32'd12, 32'd7, 0, -1);
    run_op(0, 3'b001, 1, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd2, 32'd10, 32'd0, 0, -1);
    idle(2);

    // Forwarding priority MEM_WB over WB_ID, then WB_ID alone, then none, then x0.
    MEM_WB_regwrite = 1; MEM_WB_rd = 5; WB_res = 32'd100;
    WB_ID_regwrite = 1; WB_ID_rd = 5; WB_ID_res = 32'd200;
    run_op(0, 3'b000, 0, 5'd5, 5'd5, 5'd6, 32'd1, 32'd1, 32'd0, 32'd200, 32'd100, 0, -1);
    MEM_WB_regwrite = 0;
    run_op(0, 3'b000, 0, 5'd5, 5'd5, 5'd7, 32'd1, 32'd1, 32'd0, 32'd400, 32'd200, 0, -1);
    WB_ID_regwrite = 0;
    run_op(0, 3'b000, 0, 5'd5, 5'd5, 5'd8, 32'd1, 32'd1, 32'd0, 32'd2, 32'd1, 0, -1);
    MEM_WB_regwrite = 1; MEM_WB_rd = 0; WB_res = 32'd99;
    run_op(0, 3'b000, 0, 5'd0, 5'd0, 5'd9, 32'd3, 32'd4, 32'd0, 32'd7, 32'd4, 0, -1);
    MEM_WB_regwrite = 0;

    // ALU ops: wraparound, logic, shift amount truncation, arithmetic shift.
    run_op(0, 3'b001, 0, 5'd14, 5'd15, 5'd13, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 0, -1);
    run_op(0, 3'b010, 0, 5'd14, 5'd15, 5'd13, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'h00F0_00F0, 32'h0FF0_0FF0, 0, -1);
    run_op(0, 3'b011, 0, 5'd14, 5'd15, 5'd13, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 0, -1);
    run_op(0, 3'b100, 0, 5'd14, 5'd15, 5'd13, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, -1);
    run_op(0, 3'b101, 1, 5'd14, 5'd15, 5'd13, 32'd1, 32'd0, 32'd35, 32'd8, 32'd0, 0, -1);
    run_op(0, 3'b110, 1, 5'd14, 5'd15, 5'd13, 32'h8000_0000, 32'd0, 32'd4, 32'h0800_0000, 32'd0, 0, -1);
    run_op(0, 3'b111, 1, 5'd14, 5'd15, 5'd13, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 32'd0, 0, -1);

    // Multiply / divide, normal and special cases.
    run_op(1, 3'b000, 0, 5'd10, 5'd11, 5'd12, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 33, -1);
    run_op(1, 3'b011, 0, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, -1);
    run_op(1, 3'b001, 0, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'd3, 33, -1);
    run_op(1, 3'b010, 0, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1);
    run_op(1, 3'b100, 0, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD, 32'd2, 33, -1);
    run_op(1, 3'b110, 0, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd2, 33, -1);
    run_op(1, 3'b101, 0, 5'd10, 5'd11, 5'd12, 32'd100, 32'd7, 32'd0, 32'd14, 32'd7, 33, -1);
    run_op(1, 3'b111, 0, 5'd10, 5'd11, 5'd12, 32'd100, 32'd7, 32'd0, 32'd2, 32'd7, 33, -1);
    run_op(1, 3'b101, 0, 5'd10, 5'd11, 5'd12, 32'd9, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1, -1);
    run_op(1, 3'b110, 0, 5'd10, 5'd11, 5'd12, 32'd9, 32'd0, 32'd0, 32'd9, 32'd0, 1, -1);
    run_op(1, 3'b100, 0, 5'd10, 5'd11, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1);
    run_op(1, 3'b110, 0, 5'd10, 5'd11, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, -1);

    // Debug freeze for 5 cycles mid-multiply.
    run_op(1, 3'b000, 0, 5'd10, 5'd11, 5'd12, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 38, 10);
    idle(2);

    // Asynchronous reset mid-multiply: outputs clear at once, no result follows.
    ID_EX_valid = 1; ID_EX_md = 1; ID_EX_mdop = 3'b000; ID_EX_alusrc = 0;
    ID_EX_rs1 = 10; ID_EX_rs2 = 11; ID_EX_rd = 12;
    ID_EX_dout_rs1 = 32'd7; ID_EX_dout_rs2 = 32'd3;
    repeat (5) @(negedge clk);
    #2 Rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, EX_stall}, 32'd0);
    chk("rst_mid_valid", {31'd0, EX_MEM_valid}, 32'd0);
    chk("rst_mid_alures", EX_MEM_alures, 32'd0);
    @(posedge clk);
    #1 ID_EX_valid = 0;
    @(posedge clk);
    #1 Rst = 1'b0;
    idle(40);
    chk("post_rst_stall", {31'd0, EX_stall}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised next-generation execute stage for the Mini-RISC-V pipeline.
- Contains single-cycle ALU ops and three-source operand forwarding (EX_MEM, MEM_WB, WB_ID).
- Adds an iterative RV32M multiply/divide unit that stalls the front end while busy.
- Registers results into the EX/MEM pipeline register with valid/bubble insertion and debug freeze.

Parameters:
- XLEN, 32, datapath width; must be a power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  system clock
- Rst  in  1  reset, asynchronous, active-high
- debug  in  1  freeze: while high no state changes except reset
- ID_EX_valid  in  1  instruction present in EX
- ID_EX_md  in  1  1 = M-extension op, 0 = ALU op
- ID_EX_mdop  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- ID_EX_alusel  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA
- ID_EX_alusrc  in  1  1 = operand B is ID_EX_imm
- ID_EX_regwrite  in  1  destination write enable
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  in  5 each  register addresses
- ID_EX_dout_rs1, ID_EX_dout_rs2, ID_EX_imm  in  XLEN each  register-file values and immediate
- MEM_WB_regwrite, WB_ID_regwrite  in  1 each  downstream write enables
- MEM_WB_rd, WB_ID_rd  in  5 each  downstream destinations
- WB_res, WB_ID_res  in  XLEN each  downstream results
- EX_stall  out  1  hold IF/ID/ID_EX stable
- EX_MEM_valid, EX_MEM_regwrite  out  1 each  pipeline register outputs
- EX_MEM_rd  out  5  pipeline register output
- EX_MEM_alures, EX_MEM_dout_rs2  out  XLEN each  pipeline register outputs

Behaviour:
- **Reset:** asynchronous and active-high. Clears all EX_MEM outputs and the FSM to IDLE, and zeroes the counter and operand latches. EX_stall is 0 during reset.
- **Forwarding** (per rs, rs != 0), highest priority first:
  - EX_MEM (EX_MEM_regwrite & EX_MEM_valid & rd match), forwarding EX_MEM_alures;
  - MEM_WB, forwarding WB_res;
  - WB_ID, forwarding WB_ID_res;
  - otherwise the register-file value.
  - Operand B is the immediate when alusrc = 1.
  - EX_MEM_dout_rs2 always takes the forwarded rs2.
- **ALU path:** result is ready in the same cycle.
  - Shifts use B[SHW-1:0]; SRA is arithmetic; add/sub wrap modulo 2^XLEN.
  - When ID_EX_valid & !ID_EX_md & !EX_stall & !debug: the EX_MEM register loads, with EX_MEM_valid = 1 and EX_MEM_regwrite = ID_EX_regwrite.
- **MD FSM states:** IDLE, BUSY, DONE.
  - **IDLE:** on ID_EX_valid & ID_EX_md & !debug, latch the forwarded operands, go to BUSY and load count = XLEN. EX_stall = 1 combinationally in this cycle.
  - **Special case at issue:** divide by zero or signed overflow (most-negative / -1) go straight to DONE (count skipped).
  - **BUSY:** one bit per cycle. Multiply is unsigned shift-add on magnitudes; divide is restoring division on magnitudes. The count decrements; at count == 1 go to DONE.
  - **DONE:** apply the sign fix and select the result half/field. The EX_MEM register loads with valid = 1. EX_stall = 0. Return to IDLE.
  - Latency is XLEN+1 stall cycles for normal ops and 1 stall cycle for special cases.
- **Result and sign rules:**
  - MUL gives the low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits of the 2·XLEN product.
  - The signedness of each operand follows the op.
  - DIV sign = sign(a) ^ sign(b); REM sign = sign(a).
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Overflow: quotient = dividend, remainder = 0.
- **Bubbles:** while EX_stall = 1 and not in DONE, the EX_MEM register loads a bubble (valid = 0, regwrite = 0, others don't-care but deterministic = 0). Upstream holds ID_EX_* stable while EX_stall = 1.
- **Debug:** debug = 1 freezes the FSM, counter, latches and EX_MEM outputs. EX_stall holds its value.
- **Reset mid-operation:** Rst during BUSY aborts the op; no result is written and the FSM goes to IDLE.
- **ID_EX_valid = 0** gives a bubble into EX_MEM.

Test Plan:
- Back-to-back ADD x1 = 5+7 then SUB x2 = x1-2 → the second op forwards 12 from EX_MEM; EX_MEM_alures = 10 with no stall.
- MUL 7 × -3 (XLEN = 32) → EX_stall high 33 cycles; then EX_MEM_alures = 0xFFFFFFEB with EX_MEM_valid = 1 for one cycle. Bubbles appear during the stall.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF.
- DIVU 9/0 → 0xFFFFFFFF, REM 9/0 → 9, and DIV 0x80000000/-1 → 0x80000000, each with exactly 1 stall cycle.
- debug asserted for 5 cycles mid-BUSY → count frozen; total stall = 33 + 5 and the result is unchanged.
- Rst pulse mid-BUSY (asynchronous, between edges) → outputs zero immediately, EX_stall = 0, and no valid result follows.
